// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute stage and the
// iterative multiply/divide unit.
//   start    : request, taken only while the unit is idle
//   funct3   : RV32M operation select (MUL..REMU)
//   a1, a2   : rs1 / rs2 operands
//   busy     : unit is iterating; the core holds the pipeline
//   done     : one-cycle pulse, Aout valid
//   Aout     : result, held until the next accepted start
//   zeroFlag : Aout == 0
interface muldiv_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] a1;
   logic [XLEN-1:0] a2;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] Aout;
   logic            zeroFlag;

   // Core side drives the request, observes the result.
   modport master (
      output start, funct3, a1, a2,
      input  busy, done, Aout, zeroFlag
   );

   // Unit side.
   modport slave (
      input  start, funct3, a1, a2,
      output busy, done, Aout, zeroFlag
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle.
// Shift-add multiply and restoring divide on operand magnitudes, sign fixed
// up at the end. Fixed latency: start in cycle 0, busy in cycles 1..ITER,
// done in cycle ITER+1, regardless of operands.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : muldiv_unit_if slave (start/funct3/a1/a2 in,
//              busy/done/Aout/zeroFlag out, all outputs registered)
module muldiv_unit #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ITER = 32
) (
   input  logic            clk,
   input  logic            rst,
   muldiv_unit_if.slave    bus
);

   localparam int unsigned CNT_W = $clog2(ITER);
   localparam int unsigned DW    = 2 * XLEN;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   logic [1:0]       state, state_n;
   logic [CNT_W-1:0] count;
   logic [2:0]       op;
   logic             neg_res;
   logic             div_zero;
   logic [XLEN-1:0]  acc_hi;   // product high half / partial remainder
   logic [XLEN-1:0]  acc_lo;   // multiplier bits / dividend -> quotient
   logic [XLEN-1:0]  opnd;     // multiplicand / divisor magnitude

   logic busy_n, done_n, load, step, finish;

   // Operand preparation at the accepted start.
   logic            a1_sg, a2_sg, a1_neg, a2_neg, neg_in;
   logic [XLEN-1:0] mag1, mag2;

   always_comb begin
      a1_sg = 1'b0;
      a2_sg = 1'b0;
      case (bus.funct3)
         3'b001:  begin a1_sg = 1'b1; a2_sg = 1'b1; end   // MULH
         3'b010:  a1_sg = 1'b1;                           // MULHSU
         3'b100:  begin a1_sg = 1'b1; a2_sg = 1'b1; end   // DIV
         3'b110:  begin a1_sg = 1'b1; a2_sg = 1'b1; end   // REM
         default: ;
      endcase
      a1_neg = a1_sg & bus.a1[XLEN-1];
      a2_neg = a2_sg & bus.a2[XLEN-1];
      mag1   = a1_neg ? XLEN'(-bus.a1) : bus.a1;
      mag2   = a2_neg ? XLEN'(-bus.a2) : bus.a2;
      // Remainder follows the dividend; everything else follows sign xor.
      neg_in = (bus.funct3[2] & bus.funct3[1]) ? a1_neg : (a1_neg ^ a2_neg);
   end

   // One iteration of each algorithm.
   logic [XLEN:0]   sum, shifted;
   logic            ge;
   logic [XLEN-1:0] hi_n, lo_n;

   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      shifted = {acc_hi, acc_lo[XLEN-1]};
      ge      = (shifted >= {1'b0, opnd});
      if (op[2]) begin
         // A shifted value with the carry bit set always exceeds the
         // divisor, so the difference always fits in XLEN bits.
         hi_n = ge ? XLEN'(shifted - {1'b0, opnd}) : shifted[XLEN-1:0];
         lo_n = {acc_lo[XLEN-2:0], ge};
      end else begin
         hi_n = sum[XLEN:1];
         lo_n = {sum[0], acc_lo[XLEN-1:1]};
      end
   end

   // Final result selection from the last iteration's values.
   logic [DW-1:0]   prod_s;
   logic [XLEN-1:0] quo_s, rem_s, result;

   always_comb begin
      prod_s = neg_res ? DW'(-{hi_n, lo_n}) : {hi_n, lo_n};
      quo_s  = neg_res ? XLEN'(-lo_n) : lo_n;
      rem_s  = neg_res ? XLEN'(-hi_n) : hi_n;
      case (op)
         3'b000:          result = prod_s[XLEN-1:0];
         3'b001, 3'b010,
         3'b011:          result = prod_s[DW-1:XLEN];
         // Divide by zero leaves all-ones magnitude; a negative dividend
         // would flip it, so force the quotient. The remainder naturally
         // comes out as the dividend, and signed overflow needs no override.
         3'b100, 3'b101:  result = div_zero ? '1 : quo_s;
         default:         result = rem_s;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // Next state and registered-output next values.
   always_comb begin
      state_n = state;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_n = ST_CALC;
               busy_n  = 1'b1;
               load    = 1'b1;
            end
         end
         ST_CALC: begin
            step   = 1'b1;
            busy_n = 1'b1;
            if (count == CNT_LAST) begin
               state_n = ST_DONE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               finish  = 1'b1;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Iteration datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         op       <= '0;
         neg_res  <= 1'b0;
         div_zero <= 1'b0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd     <= '0;
      end else if (load) begin
         count    <= '0;
         op       <= bus.funct3;
         neg_res  <= neg_in;
         div_zero <= (bus.a2 == '0);
         acc_hi   <= '0;
         acc_lo   <= bus.funct3[2] ? mag1 : mag2;
         opnd     <= bus.funct3[2] ? mag2 : mag1;
      end else if (step) begin
         count    <= count + CNT_W'(1);
         acc_hi   <= hi_n;
         acc_lo   <= lo_n;
      end
   end

   // Registered outputs; Aout and zeroFlag update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.Aout     <= '0;
         bus.zeroFlag <= 1'b1;
      end else begin
         bus.busy <= busy_n;
         bus.done <= done_n;
         if (finish) begin
            bus.Aout     <= result;
            bus.zeroFlag <= (result == '0);
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit results,
// latency, handshake and reset behaviour against a 64-bit reference model.
module tb_muldiv_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   muldiv_unit_if #(.XLEN(32)) mdu ();

   muldiv_unit #(.XLEN(32), .ITER(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (mdu)
   );

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] res;
   } sb_t;

   sb_t sb_q[$];
   int  n_assert = 0;
   int  n_fail   = 0;

   // Reference model using native wide arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [63:0] sa, sb, ub_s, ps;
      logic [63:0]        ua, ub, pu;
      logic [31:0]        r;
      sa   = {{32{a[31]}}, a};
      sb   = {{32{b[31]}}, b};
      ua   = {32'd0, a};
      ub   = {32'd0, b};
      ub_s = {32'd0, b};
      r    = '0;
      case (f3)
         3'd0: begin pu = ua * ub;   r = pu[31:0];  end
         3'd1: begin ps = sa * sb;   r = ps[63:32]; end
         3'd2: begin ps = sa * ub_s; r = ps[63:32]; end
         3'd3: begin pu = ua * ub;   r = pu[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = 32'($signed(a) / $signed(b));
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
            else r = 32'($signed(a) % $signed(b));
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op in cycle 0; optional stray start pulses in cycles p1/p2
   // carry different operands. Checks latency, busy length and result,
   // then that Aout holds with no further done for 10 idle cycles.
   task automatic run_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] x, input logic [31:0] y,
                         input int p1, input int p2);
      int  bc, dc, extra;
      sb_t e;
      @(posedge clk); #1;
      mdu.start  = 1'b1;
      mdu.funct3 = f3;
      mdu.a1     = x;
      mdu.a2     = y;
      sb_q.push_back('{f3: f3, res: ref_model(f3, x, y)});
      bc = 0;
      dc = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         mdu.start = (k == p1 || k == p2);
         if (mdu.start) begin
            mdu.funct3 = 3'd0;
            mdu.a1     = ~x;
            mdu.a2     = 32'd3;
         end
         @(negedge clk);
         if (mdu.busy) bc++;
         if (mdu.done) begin
            dc = k;
            break;
         end
      end
      check({tag, " done_cycle"}, 32'(dc), 32'd33);
      check({tag, " busy_cycles"}, 32'(bc), 32'd32);
      if (sb_q.size() == 0) begin
         check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
         e = '0;
      end else begin
         e = sb_q.pop_front();
      end
      check({tag, " Aout"}, mdu.Aout, e.res);
      check({tag, " zeroFlag"}, 32'(mdu.zeroFlag), 32'(e.res == 0));
      extra = 0;
      for (int j = 0; j < 10; j++) begin
         @(posedge clk); #1;
         mdu.start = 1'b0;
         @(negedge clk);
         if (mdu.done || mdu.busy) extra++;
         if (mdu.Aout !== e.res) extra++;
      end
      check({tag, " hold"}, 32'(extra), 32'd0);
   endtask

   initial begin
      mdu.start  = 1'b0;
      mdu.funct3 = 3'd0;
      mdu.a1     = '0;
      mdu.a2     = '0;
      rst        = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", 32'(mdu.busy), 32'd0);
      check("reset done", 32'(mdu.done), 32'd0);
      check("reset Aout", mdu.Aout, 32'd0);
      check("reset zeroFlag", 32'(mdu.zeroFlag), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      run_op("MUL 7*-3",       3'd0, 32'd7,          32'hFFFF_FFFD, -1, -1);
      run_op("MULH -1*-1",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, -1, -1);
      run_op("MULHU -1*-1",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, -1, -1);
      run_op("MULHSU -1*-1",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, -1, -1);
      run_op("DIV -7/2",       3'd4, 32'hFFFF_FFF9,  32'd2,         -1, -1);
      run_op("REM -7/2",       3'd6, 32'hFFFF_FFF9,  32'd2,         -1, -1);
      run_op("DIVU 100/7",     3'd5, 32'd100,        32'd7,         -1, -1);
      run_op("DIVU 5/0",       3'd5, 32'd5,          32'd0,         -1, -1);
      run_op("REMU 5/0",       3'd7, 32'd5,          32'd0,         -1, -1);
      run_op("DIV ovf",        3'd4, 32'h8000_0000,  32'hFFFF_FFFF, -1, -1);
      run_op("REM ovf",        3'd6, 32'h8000_0000,  32'hFFFF_FFFF, -1, -1);
      run_op("DIV -9/0",       3'd4, 32'hFFFF_FFF7,  32'd0,         -1, -1);
      run_op("REM -9/0",       3'd6, 32'hFFFF_FFF7,  32'd0,         -1, -1);
      run_op("MULHSU mix",     3'd2, 32'h8000_0001,  32'hC000_0000, -1, -1);
      run_op("stray starts",   3'd5, 32'd1000,       32'd9,          5, 33);

      for (int i = 0; i < 8; i++) begin
         run_op("random", 3'(i), $urandom, $urandom, -1, -1);
      end

      // Leave a nonzero result so the reset check is meaningful.
      run_op("pre-reset MUL",  3'd0, 32'd1234,       32'd5678,      -1, -1);

      // Reset during a DIV in cycle 12.
      @(posedge clk); #1;
      mdu.start  = 1'b1;
      mdu.funct3 = 3'd4;
      mdu.a1     = 32'hFFFF_0000;
      mdu.a2     = 32'd3;
      sb_q.push_back('{f3: 3'd4, res: ref_model(3'd4, 32'hFFFF_0000, 32'd3)});
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         mdu.start = 1'b0;
         if (k == 12) rst = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      void'(sb_q.pop_front());
      @(negedge clk);
      check("abort busy", 32'(mdu.busy), 32'd0);
      check("abort done", 32'(mdu.done), 32'd0);
      check("abort Aout", mdu.Aout, 32'd0);
      check("abort zeroFlag", 32'(mdu.zeroFlag), 32'd1);

      run_op("post-reset DIV", 3'd4, 32'hFFFF_0000,  32'd3,         -1, -1);
      check("scoreboard drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
